wb_interconnect: RTL

//  Parametrised single-master, N-slave Wishbone B4 (classic) interconnect.

---
 rtl/wb_interconnect_pkg.sv | 23 ++
 rtl/wb_addr_decode.sv | 36 +++
 rtl/wb_interconnect.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wb_interconnect_pkg.sv
// Shared definitions for the Wishbone interconnect: FSM state encoding,
// default error data word and the watchdog width helper.
package wb_interconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } wb_state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Counter width able to hold 0..timeout, never narrower than one bit.
    function automatic int wdog_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational priority address decoder: reports whether any window matches
// and the index of the lowest-numbered matching slave.
module wb_addr_decode #(
    parameter int N_SLAVES   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic                  hit,
    output logic [IDX_WIDTH-1:0]  idx
);

    logic [N_SLAVES-1:0] hits;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_hit
            assign hits[gi] = (adr & SLAVE_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                              == SLAVE_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        hit = |hits;
        idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (hits[k]) begin
                idx = k[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone classic interconnect with registered decode,
// per-transfer watchdog and bus-error termination of unmapped or hung accesses.
module wb_interconnect
    import wb_interconnect_pkg::*;
#(
    parameter int N_SLAVES       = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          m_adr,
    input  logic [DATA_WIDTH-1:0]          m_datwr,
    output logic [DATA_WIDTH-1:0]          m_datrd,
    input  logic                           m_we,
    input  logic [DATA_WIDTH/8-1:0]        m_sel,
    input  logic                           m_stb,
    input  logic                           m_cyc,
    output logic                           m_ack,
    output logic                           m_err,
    output logic [ADDR_WIDTH-1:0]          s_adr,
    output logic [DATA_WIDTH-1:0]          s_datwr,
    output logic                           s_we,
    output logic [DATA_WIDTH/8-1:0]        s_sel,
    output logic [N_SLAVES-1:0]            s_cyc,
    output logic [N_SLAVES-1:0]            s_stb,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_datrd,
    input  logic [N_SLAVES-1:0]            s_ack,
    output logic [ADDR_WIDTH-1:0]          err_adr,
    output logic                           err_timeout
);

    localparam int IDX_WIDTH  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int WDOG_WIDTH = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    wb_state_t               state_reg, state_next;
    logic [IDX_WIDTH-1:0]    sel_reg;
    logic [WDOG_WIDTH-1:0]   wdog_reg;
    logic [ADDR_WIDTH-1:0]   err_adr_reg;
    logic                    err_timeout_reg;

    logic                    dec_hit;
    logic [IDX_WIDTH-1:0]    dec_idx;
    logic                    sel_ack;
    logic                    timeout_hit;
    logic                    req;
    logic [DATA_WIDTH-1:0]   slave_rd [N_SLAVES];

    wb_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .adr (m_adr),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_rd
            assign slave_rd[gi] = s_datrd[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign s_adr       = m_adr;
    assign s_datwr     = m_datwr;
    assign s_we        = m_we;
    assign s_sel       = m_sel;
    assign err_adr     = err_adr_reg;
    assign err_timeout = err_timeout_reg;
    assign req         = m_cyc & m_stb;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog_reg == WDOG_LAST);

    always_comb begin
        state_next = state_reg;
        s_cyc      = '0;
        s_stb      = '0;
        m_ack      = 1'b0;
        m_err      = 1'b0;
        m_datrd    = '0;
        sel_ack    = s_ack[sel_reg];
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = dec_hit ? ST_ACTIVE : ST_ERR;
                end
            end
            ST_ACTIVE: begin
                s_cyc[sel_reg] = m_cyc;
                s_stb[sel_reg] = m_stb;
                // An abort outranks a late ack; an ack outranks the watchdog.
                if (!m_cyc) begin
                    state_next = ST_IDLE;
                end else if (sel_ack) begin
                    m_ack      = 1'b1;
                    m_datrd    = slave_rd[sel_reg];
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_ERR: begin
                m_err      = 1'b1;
                m_datrd    = ERR_DATA;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            sel_reg         <= '0;
            wdog_reg        <= '0;
            err_adr_reg     <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req) begin
                if (dec_hit) begin
                    sel_reg <= dec_idx;
                end else begin
                    err_adr_reg     <= m_adr;
                    err_timeout_reg <= 1'b0;
                end
            end
            if (state_reg == ST_ACTIVE && state_next == ST_ERR) begin
                err_adr_reg     <= m_adr;
                err_timeout_reg <= 1'b1;
            end
            if (state_reg == ST_ACTIVE && state_next == ST_ACTIVE) begin
                wdog_reg <= wdog_reg + 1'b1;
            end else begin
                wdog_reg <= '0;
            end
        end
    end

endmodule
